regfile_nr1w: RTL
=================

REGFILE_NR1W -- requirements
Module: regfile_nr1w

Interface
REQ-001 Parameter WIDTH, default 32, data bits per register; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 32, number of registers; AW = clog2(DEPTH).
REQ-003 Parameter NRD, default 2, number of read ports, range 1..4.
REQ-004 Parameter ZERO_REG, default 1; when 1, register 0 SHALL read as zero and ignore writes.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 we  input  1  write request.
REQ-008 waddr  input  AW  write address.
REQ-009 wdata  input  WIDTH  write data.
REQ-010 wbe  input  WIDTH/8  byte enables; bit i covers wdata[8i+7:8i].
REQ-011 rd_en  input  NRD  per-port read request.
REQ-012 raddr  input  NRD*AW  packed read addresses; port p at [p*AW +: AW].
REQ-013 rd_data  output  NRD*WIDTH  packed registered read data.
REQ-014 rd_valid  output  NRD  per-port pulse: rd_data for that port updated this cycle.
REQ-015 rd_err  output  NRD  per-port pulse: the completed read addressed >= DEPTH.
REQ-016 wr_err  output  1  one-cycle pulse: the previous write addressed >= DEPTH.

Function
REQ-017 Write: on an edge with we=1, waddr<DEPTH, and a non-zero target (ZERO_REG case), bytes with wbe=1 SHALL update; bytes with wbe=0 SHALL hold.
REQ-018 we=1 with wbe=0 SHALL leave storage unchanged and raise no error.
REQ-019 Read latency SHALL be exactly 1 cycle: rd_en[p] at edge T gives rd_data[p], rd_valid[p]=1 after edge T.
REQ-020 rd_data[p] SHALL hold its last value while rd_en[p]=0; rd_valid[p] SHALL be 0 in those cycles.
REQ-021 Read-during-write to the same address at the same edge SHALL return the post-write value: new bytes where wbe=1, old bytes elsewhere.
REQ-022 All NRD ports SHALL be independent; any number of them may read the same address in one cycle.
REQ-023 Read of address >= DEPTH SHALL return all-zero data with rd_valid=1 and rd_err=1.
REQ-024 Write to address >= DEPTH SHALL be dropped, and wr_err SHALL be 1 for the following cycle.
REQ-025 With ZERO_REG=1, a read of address 0 SHALL return zero, including when a write to 0 occurs in the same cycle; no error flag SHALL be raised.

Reset
REQ-026 Asserting reset SHALL immediately clear all registers, rd_data, rd_valid, rd_err and wr_err to 0, independent of clk.
REQ-027 A write or read in flight when reset asserts SHALL be discarded.
REQ-028 The first edge after reset deassertion SHALL accept we and rd_en normally.

Structure
REQ-029 Package regfile_pkg SHALL hold the default WIDTH, DEPTH and NRD values, and a clog2 helper function.
REQ-030 Sub-module regfile_word SHALL implement one WIDTH-bit register with per-byte enable and asynchronous reset; it SHALL be instantiated DEPTH times, or DEPTH-1 times when ZERO_REG=1.
REQ-031 The read muxes and the bypass merge SHALL be in regfile_nr1w; there SHALL be no latches and no combinational path from inputs to outputs.

Verification (defaults WIDTH=32, DEPTH=32, NRD=2, ZERO_REG=1)
REQ-032 Reset: pulse reset mid-cycle after writing 0xDEADBEEF to r5, then read r5 on port 0 -> rd_data0=0x00000000, rd_valid0=1 one cycle later.
REQ-033 Byte enables: r7=0x11223344, then write 0xAABBCCDD with wbe=4'b0101, then read r7 -> 0x11BB33DD.
REQ-034 Bypass: r9=0x0, then in the same cycle write r9=0x12345678 (wbe=4'hF) and read r9 on both ports -> both ports give 0x12345678 next cycle.
REQ-035 Zero register: write r0=0xFFFFFFFF while port 1 reads r0 -> rd_data1=0, wr_err=0; a later read of r0 -> 0.
REQ-036 Out of range: a bench with DEPTH=24 writes address 30 -> wr_err=1 for one cycle, no register changes; reading address 30 -> rd_data=0, rd_err=1, rd_valid=1.
REQ-037 Hold: read r3=0x0000ABCD, then drop rd_en for 3 cycles while writing r3=0x1 -> rd_data stays 0x0000ABCD, rd_valid=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and the address-width helper for the register file.
package regfile_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 32;
    localparam int DEF_NRD   = 2;
    // Returns at least 1 so a single-entry file still has a usable address port.
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/regfile_nr1w_word.sv
// regfile_word: one WIDTH-bit register with per-byte write enable.
//   clk, reset (async, active-high), we_i, wbe_i (byte enables), wdata_i, q_o (stored word)
module regfile_word
    import regfile_pkg::*;
#(
    parameter int  WIDTH = DEF_WIDTH,
    localparam int NB    = WIDTH / 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we_i,
    input  logic [NB-1:0]    wbe_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] q_q, q_d;
    always_comb begin
        q_d = q_q;
        for (int b = 0; b < NB; b++)
            if (we_i && wbe_i[b]) q_d[8*b +: 8] = wdata_i[8*b +: 8];
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) q_q <= '0;
        else       q_q <= q_d;
    assign q_o = q_q;
endmodule

// File: rtl/regfile_nr1w.sv
// regfile_nr1w: NRD-read / 1-write register file with byte enables, write-through bypass and range errors.
//   clk, reset (async, active-high); write: we, waddr, wdata, wbe -> wr_err pulse for out-of-range writes
//   read (per port p): rd_en[p], raddr[p*AW +: AW] -> registered rd_data[p*WIDTH +: WIDTH], rd_valid[p], rd_err[p]
module regfile_nr1w
    import regfile_pkg::*;
#(
    parameter int  WIDTH    = DEF_WIDTH,
    parameter int  DEPTH    = DEF_DEPTH,
    parameter int  NRD      = DEF_NRD,
    parameter int  ZERO_REG = 1,
    localparam int AW       = clog2(DEPTH),
    localparam int NB       = WIDTH / 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [NB-1:0]        wbe,
    input  logic [NRD-1:0]       rd_en,
    input  logic [NRD*AW-1:0]    raddr,
    output logic [NRD*WIDTH-1:0] rd_data,
    output logic [NRD-1:0]       rd_valid,
    output logic [NRD-1:0]       rd_err,
    output logic                 wr_err
);
    localparam logic [AW:0] LIM = (AW+1)'(DEPTH);
    genvar i, p, b;
    // The array spans the whole address space; slots past DEPTH and the zero
    // register are tied to zero, so out-of-range reads return zero for free.
    logic [WIDTH-1:0] mem [2**AW];
    for (i = 0; i < 2**AW; i++) begin : g_mem
        if (i >= DEPTH || (ZERO_REG != 0 && i == 0)) begin : g_zero
            assign mem[i] = '0;
        end else begin : g_word
            regfile_word #(.WIDTH(WIDTH)) u_word (
                .clk     (clk),
                .reset   (reset),
                .we_i    (we && waddr == AW'(i)),
                .wbe_i   (wbe),
                .wdata_i (wdata),
                .q_o     (mem[i])
            );
        end
    end
    logic wr_err_q, wr_err_d;
    assign wr_err_d = we && |wbe && ({1'b0, waddr} >= LIM);
    always_ff @(posedge clk or posedge reset)
        if (reset) wr_err_q <= 1'b0;
        else       wr_err_q <= wr_err_d;
    assign wr_err = wr_err_q;
    for (p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]    addr;
        logic             in_range, hit;
        logic [WIDTH-1:0] merged, data_d, data_q;
        logic             valid_q, err_q;
        assign addr     = raddr[p*AW +: AW];
        assign in_range = {1'b0, addr} < LIM;
        // Bypass only into real storage: never the zero register, never past DEPTH.
        assign hit      = we && waddr == addr && in_range && !(ZERO_REG != 0 && addr == '0);
        for (b = 0; b < NB; b++) begin : g_byte
            assign merged[8*b +: 8] = (hit && wbe[b]) ? wdata[8*b +: 8] : mem[addr][8*b +: 8];
        end
        assign data_d = rd_en[p] ? merged : data_q;
        always_ff @(posedge clk or posedge reset)
            if (reset) begin
                data_q  <= '0;
                valid_q <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                data_q  <= data_d;
                valid_q <= rd_en[p];
                err_q   <= rd_en[p] && !in_range;
            end
        assign rd_data[p*WIDTH +: WIDTH] = data_q;
        assign rd_valid[p]               = valid_q;
        assign rd_err[p]                 = err_q;
    end
endmodule
